// File: rtl/lcd_frame_capture_if.sv
// Bundles the LCD pixel stream (from the PPU) and the framebuffer write port into one interface.
// The slave modport is the capture block; the master side drives pixels and observes writes.
interface lcd_frame_capture_if;
    logic [1:0]  pixel_data;
    logic        pixel_latch;
    logic        hsync;
    logic        vsync;
    logic [13:0] fb_addr;
    logic [7:0]  fb_data;
    logic        fb_we;
    logic        fb_bank;
    logic        frame_done;
    logic        err_overflow;

    modport master (
        output pixel_data, pixel_latch, hsync, vsync,
        input  fb_addr, fb_data, fb_we, fb_bank, frame_done, err_overflow
    );

    modport slave (
        input  pixel_data, pixel_latch, hsync, vsync,
        output fb_addr, fb_data, fb_we, fb_bank, frame_done, err_overflow
    );
endinterface

// File: rtl/lcd_frame_capture.sv
// Captures the 2bpp LCD stream, packs four pixels per byte and writes them into the bank the
// display is not reading; banks swap only when a frame delivered all HEIGHT lines.
module lcd_frame_capture #(
    parameter int WIDTH   = 160,
    parameter int HEIGHT  = 144,
    parameter int BANK_SZ = WIDTH * HEIGHT / 4
) (
    input  logic               clock,
    input  logic               reset,
    lcd_frame_capture_if.slave lcd
);
    localparam int AW = 14;
    localparam int XW = $clog2(WIDTH + 1);
    localparam int YW = $clog2(HEIGHT + 1);
    localparam logic [XW-1:0] X_END      = XW'(WIDTH);
    localparam logic [YW-1:0] Y_END      = YW'(HEIGHT);
    localparam logic [AW-1:0] LINE_BYTES = AW'(WIDTH / 4);
    localparam logic [AW-1:0] BANK1_BASE = AW'(BANK_SZ);

    typedef enum logic [1:0] {SYNC_WAIT, CAPTURE, FLUSH, HOLD} state_t;

    state_t        state, state_nxt;
    logic          hsync_q, vsync_q, h_rise, v_rise;
    logic [XW-1:0] x, x_nxt, x_upd;
    logic [YW-1:0] y, y_nxt, y_inc;
    logic [AW-1:0] line_base, line_base_nxt, byte_addr;
    logic [7:0]    pack, pack_nxt, pix_byte;
    logic [1:0]    pad;
    logic          pix_take, end_line;
    logic [AW-1:0] addr_q, addr_nxt;
    logic [7:0]    data_q, data_nxt;
    logic          we_q, we_nxt, bank_q, bank_nxt, done_q, done_nxt, err_q, err_nxt;

    assign h_rise   = lcd.hsync & ~hsync_q;
    assign v_rise   = lcd.vsync & ~vsync_q;
    // A pixel arriving with vsync belongs to no frame and is dropped.
    assign pix_take = (state == CAPTURE) && lcd.pixel_latch && !v_rise && (x != X_END);
    assign x_upd    = pix_take ? x + 1'b1 : x;
    assign y_inc    = y + 1'b1;
    assign pix_byte = {pack[5:0], lcd.pixel_data};
    // Left-justify a partial group: shift by 2*(4 - x%4) bits.
    assign pad      = 2'd0 - x[1:0];
    assign byte_addr = (bank_q ? '0 : BANK1_BASE) + line_base + AW'(x[XW-1:2]);
    // Flush decision sees the x that already includes a coincident pixel.
    assign end_line = !v_rise && ((state == CAPTURE && h_rise && x_upd[1:0] == 2'b00) ||
                                  state == FLUSH);

    // NOTE: registers are written only in always_ff with <=; the combinational blocks use =.
    always_ff @(posedge clock) begin
        if (reset) state <= SYNC_WAIT;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (v_rise) begin
            state_nxt = CAPTURE;
        end else begin
            if (state == CAPTURE && h_rise && x_upd[1:0] != 2'b00) state_nxt = FLUSH;
            if (end_line) state_nxt = (y_inc == Y_END) ? HOLD : CAPTURE;
        end
    end

    // NOTE: every signal driven here gets a default first, so no latch can be inferred.
    always_comb begin
        x_nxt         = x;
        y_nxt         = y;
        line_base_nxt = line_base;
        pack_nxt      = pack;
        we_nxt        = 1'b0;
        addr_nxt      = addr_q;
        data_nxt      = data_q;
        bank_nxt      = bank_q;
        done_nxt      = 1'b0;
        err_nxt       = err_q;
        if (v_rise) begin
            if (state != SYNC_WAIT && y == Y_END) begin
                bank_nxt = ~bank_q;
                done_nxt = 1'b1;
            end
            x_nxt         = '0;
            y_nxt         = '0;
            line_base_nxt = '0;
            pack_nxt      = '0;
        end else begin
            unique case (state)
                SYNC_WAIT: begin
                end
                CAPTURE: begin
                    if (pix_take) begin
                        pack_nxt = pix_byte;
                        x_nxt    = x_upd;
                        if (x_upd[1:0] == 2'b00) begin
                            we_nxt   = 1'b1;
                            addr_nxt = byte_addr;
                            data_nxt = pix_byte;
                        end
                    end else if (lcd.pixel_latch) begin
                        err_nxt = 1'b1;
                    end
                end
                FLUSH: begin
                    we_nxt   = 1'b1;
                    addr_nxt = byte_addr;
                    data_nxt = pack << {pad, 1'b0};
                end
                HOLD: begin
                    if (lcd.pixel_latch || h_rise) err_nxt = 1'b1;
                end
            endcase
            if (end_line) begin
                x_nxt         = '0;
                y_nxt         = y_inc;
                line_base_nxt = line_base + LINE_BYTES;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            hsync_q   <= 1'b0;
            vsync_q   <= 1'b0;
            x         <= '0;
            y         <= '0;
            line_base <= '0;
            pack      <= '0;
            addr_q    <= '0;
            data_q    <= '0;
            we_q      <= 1'b0;
            bank_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            hsync_q   <= lcd.hsync;
            vsync_q   <= lcd.vsync;
            x         <= x_nxt;
            y         <= y_nxt;
            line_base <= line_base_nxt;
            pack      <= pack_nxt;
            addr_q    <= addr_nxt;
            data_q    <= data_nxt;
            we_q      <= we_nxt;
            bank_q    <= bank_nxt;
            done_q    <= done_nxt;
            err_q     <= err_nxt;
        end
    end

    assign lcd.fb_addr      = addr_q;
    assign lcd.fb_data      = data_q;
    assign lcd.fb_we        = we_q;
    assign lcd.fb_bank      = bank_q;
    assign lcd.frame_done   = done_q;
    assign lcd.err_overflow = err_q;
endmodule
